// File: rtl/uart_fifo_unit.sv
// Full-duplex UART with independent TX and RX FIFOs and valid/ready handshakes.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_tx_data/valid       byte offered for transmission; o_tx_ready = TX FIFO not full
//   o_rx_data/valid       head of RX FIFO (first-word fall-through); i_rx_ready pops it
//   i_clr_err             one-cycle pulse clearing the sticky error flags
//   o_tx_busy             TX FIFO non-empty or a frame still on the line
//   o_tx_count/rx_count   FIFO occupancies
//   o_rx_frame_err        sticky: stop bit sampled low
//   o_rx_parity_err       sticky: parity mismatch
//   o_rx_overrun          sticky: good frame dropped because the RX FIFO was full
//   o_txd / i_rxd         serial pins, idle high; i_rxd is asynchronous
module uart_fifo_unit #(
   parameter int unsigned CLK_PER_BIT = 868,
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned PARITY      = 0,
   parameter int unsigned FIFO_DEPTH  = 16
) (
   input  logic                              i_clk,
   input  logic                              i_rst,
   input  logic [DATA_W-1:0]                 i_tx_data,
   input  logic                              i_tx_valid,
   output logic                              o_tx_ready,
   output logic [DATA_W-1:0]                 o_rx_data,
   output logic                              o_rx_valid,
   input  logic                              i_rx_ready,
   input  logic                              i_clr_err,
   output logic                              o_tx_busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_tx_count,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_rx_count,
   output logic                              o_rx_frame_err,
   output logic                              o_rx_parity_err,
   output logic                              o_rx_overrun,
   output logic                              o_txd,
   input  logic                              i_rxd
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned TW = $clog2(CLK_PER_BIT);
   localparam int unsigned BW = $clog2(DATA_W);

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StStart = 3'd1;
   localparam logic [2:0] StData  = 3'd2;
   localparam logic [2:0] StPar   = 3'd3;
   localparam logic [2:0] StStop  = 3'd4;
   localparam logic [2:0] StWait  = 3'd5;

   // ---------------------------------------------------------------- TX FIFO
   logic [DATA_W-1:0] r_tx_mem [FIFO_DEPTH];
   logic [AW-1:0]     r_tx_wr, r_tx_rd;
   logic [CW-1:0]     r_tx_cnt;
   logic              w_tx_full, w_tx_empty, w_tx_push, w_tx_pop;
   logic [DATA_W-1:0] w_tx_head;
   logic              w_tx_head_par;

   assign w_tx_full  = (r_tx_cnt == CW'(FIFO_DEPTH));
   assign w_tx_empty = (r_tx_cnt == '0);
   assign w_tx_push  = i_tx_valid && !w_tx_full;
   assign w_tx_head  = r_tx_mem[r_tx_rd];
   assign w_tx_head_par = (PARITY == 2) ? ~^w_tx_head : ^w_tx_head;

   always_ff @(posedge i_clk) begin
      if (w_tx_push) r_tx_mem[r_tx_wr] <= i_tx_data;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_tx_wr  <= '0;
         r_tx_rd  <= '0;
         r_tx_cnt <= '0;
      end else begin
         if (w_tx_push) r_tx_wr <= r_tx_wr + AW'(1);
         if (w_tx_pop)  r_tx_rd <= r_tx_rd + AW'(1);
         case ({w_tx_push, w_tx_pop})
            2'b10:   r_tx_cnt <= r_tx_cnt + CW'(1);
            2'b01:   r_tx_cnt <= r_tx_cnt - CW'(1);
            default: r_tx_cnt <= r_tx_cnt;
         endcase
      end
   end

   // ---------------------------------------------------------------- TX FSM
   logic [2:0]        r_tx_state, w_tx_state_nxt;
   logic [TW-1:0]     r_tx_tick, w_tx_tick_nxt;
   logic [BW-1:0]     r_tx_bit, w_tx_bit_nxt;
   logic [DATA_W-1:0] r_tx_shift, w_tx_shift_nxt;
   logic              r_tx_par, w_tx_par_nxt;
   logic              r_txd, w_txd_nxt;
   logic              r_tx_active;
   logic              w_tx_bit_end;

   assign w_tx_bit_end = (r_tx_tick == TW'(CLK_PER_BIT - 1));

   always_comb begin
      w_tx_state_nxt = r_tx_state;
      w_tx_tick_nxt  = r_tx_tick + TW'(1);
      w_tx_bit_nxt   = r_tx_bit;
      w_tx_shift_nxt = r_tx_shift;
      w_tx_par_nxt   = r_tx_par;
      w_tx_pop       = 1'b0;
      if (w_tx_bit_end) w_tx_tick_nxt = '0;
      case (r_tx_state)
         StIdle: begin
            w_tx_tick_nxt = '0;
            if (!w_tx_empty) begin
               w_tx_pop       = 1'b1;
               w_tx_shift_nxt = w_tx_head;
               w_tx_par_nxt   = w_tx_head_par;
               w_tx_state_nxt = StStart;
            end
         end
         StStart: begin
            if (w_tx_bit_end) begin
               w_tx_bit_nxt   = '0;
               w_tx_state_nxt = StData;
            end
         end
         StData: begin
            if (w_tx_bit_end) begin
               w_tx_shift_nxt = r_tx_shift >> 1;
               if (r_tx_bit == BW'(DATA_W - 1)) begin
                  w_tx_state_nxt = (PARITY != 0) ? StPar : StStop;
               end else begin
                  w_tx_bit_nxt = r_tx_bit + BW'(1);
               end
            end
         end
         StPar: begin
            if (w_tx_bit_end) w_tx_state_nxt = StStop;
         end
         StStop: begin
            if (w_tx_bit_end) begin
               // Chain straight into the next start bit when more data is queued.
               if (!w_tx_empty) begin
                  w_tx_pop       = 1'b1;
                  w_tx_shift_nxt = w_tx_head;
                  w_tx_par_nxt   = w_tx_head_par;
                  w_tx_state_nxt = StStart;
               end else begin
                  w_tx_state_nxt = StIdle;
               end
            end
         end
         default: w_tx_state_nxt = StIdle;
      endcase
   end

   always_comb begin
      w_txd_nxt = 1'b1;
      case (r_tx_state)
         StStart: w_txd_nxt = 1'b0;
         StData:  w_txd_nxt = r_tx_shift[0];
         StPar:   w_txd_nxt = r_tx_par;
         default: w_txd_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_tx_state  <= StIdle;
         r_tx_tick   <= '0;
         r_tx_bit    <= '0;
         r_tx_shift  <= '0;
         r_tx_par    <= 1'b0;
         r_txd       <= 1'b1;
         r_tx_active <= 1'b0;
      end else begin
         r_tx_state  <= w_tx_state_nxt;
         r_tx_tick   <= w_tx_tick_nxt;
         r_tx_bit    <= w_tx_bit_nxt;
         r_tx_shift  <= w_tx_shift_nxt;
         r_tx_par    <= w_tx_par_nxt;
         r_txd       <= w_txd_nxt;
         r_tx_active <= (r_tx_state != StIdle);
      end
   end

   // txd lags the FSM by one register; r_tx_active covers that last stop cycle.
   assign o_txd      = r_txd;
   assign o_tx_ready = !w_tx_full;
   assign o_tx_count = r_tx_cnt;
   assign o_tx_busy  = !w_tx_empty || (r_tx_state != StIdle) || r_tx_active;

   // ---------------------------------------------------------------- RX FSM
   logic              r_rx_meta, r_rx_sync;
   logic [2:0]        r_rx_state, w_rx_state_nxt;
   logic [TW-1:0]     r_rx_tick, w_rx_tick_nxt;
   logic [BW-1:0]     r_rx_bit, w_rx_bit_nxt;
   logic [DATA_W-1:0] r_rx_shift, w_rx_shift_nxt;
   logic              r_rx_par_bit, w_rx_par_bit_nxt;
   logic              w_rx_bit_end, w_rx_half;
   logic              w_rx_par_ok;
   logic              w_rx_wr, w_set_fe, w_set_pe;

   assign w_rx_bit_end = (r_rx_tick == TW'(CLK_PER_BIT - 1));
   assign w_rx_half    = (r_rx_tick == TW'(CLK_PER_BIT / 2 - 1));
   assign w_rx_par_ok  = (PARITY == 0) || ((^{r_rx_shift, r_rx_par_bit}) == (PARITY == 2));

   always_comb begin
      w_rx_state_nxt   = r_rx_state;
      w_rx_tick_nxt    = r_rx_tick + TW'(1);
      w_rx_bit_nxt     = r_rx_bit;
      w_rx_shift_nxt   = r_rx_shift;
      w_rx_par_bit_nxt = r_rx_par_bit;
      w_rx_wr          = 1'b0;
      w_set_fe         = 1'b0;
      w_set_pe         = 1'b0;
      case (r_rx_state)
         StIdle: begin
            w_rx_tick_nxt = '0;
            if (!r_rx_sync) w_rx_state_nxt = StStart;
         end
         StStart: begin
            // Re-check at mid start bit; a high line means it was only a glitch.
            if (w_rx_half) begin
               w_rx_tick_nxt = '0;
               if (r_rx_sync) begin
                  w_rx_state_nxt = StIdle;
               end else begin
                  w_rx_bit_nxt   = '0;
                  w_rx_state_nxt = StData;
               end
            end
         end
         StData: begin
            if (w_rx_bit_end) begin
               w_rx_tick_nxt  = '0;
               w_rx_shift_nxt = {r_rx_sync, r_rx_shift[DATA_W-1:1]};
               if (r_rx_bit == BW'(DATA_W - 1)) begin
                  w_rx_state_nxt = (PARITY != 0) ? StPar : StStop;
               end else begin
                  w_rx_bit_nxt = r_rx_bit + BW'(1);
               end
            end
         end
         StPar: begin
            if (w_rx_bit_end) begin
               w_rx_tick_nxt    = '0;
               w_rx_par_bit_nxt = r_rx_sync;
               w_rx_state_nxt   = StStop;
            end
         end
         StStop: begin
            if (w_rx_bit_end) begin
               w_rx_tick_nxt = '0;
               if (!r_rx_sync) begin
                  w_set_fe       = 1'b1;
                  w_rx_state_nxt = StWait;
               end else if (!w_rx_par_ok) begin
                  w_set_pe       = 1'b1;
                  w_rx_state_nxt = StIdle;
               end else begin
                  w_rx_wr        = 1'b1;
                  w_rx_state_nxt = StIdle;
               end
            end
         end
         StWait: begin
            // After a framing error, hold off until the line returns high.
            w_rx_tick_nxt = '0;
            if (r_rx_sync) w_rx_state_nxt = StIdle;
         end
         default: w_rx_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rx_meta    <= 1'b1;
         r_rx_sync    <= 1'b1;
         r_rx_state   <= StIdle;
         r_rx_tick    <= '0;
         r_rx_bit     <= '0;
         r_rx_shift   <= '0;
         r_rx_par_bit <= 1'b0;
      end else begin
         r_rx_meta    <= i_rxd;
         r_rx_sync    <= r_rx_meta;
         r_rx_state   <= w_rx_state_nxt;
         r_rx_tick    <= w_rx_tick_nxt;
         r_rx_bit     <= w_rx_bit_nxt;
         r_rx_shift   <= w_rx_shift_nxt;
         r_rx_par_bit <= w_rx_par_bit_nxt;
      end
   end

   // ---------------------------------------------------------------- RX FIFO
   logic [DATA_W-1:0] r_rx_mem [FIFO_DEPTH];
   logic [AW-1:0]     r_rx_wr_ptr, r_rx_rd_ptr;
   logic [CW-1:0]     r_rx_cnt;
   logic              w_rx_full, w_rx_pop, w_rx_push, w_set_ov;
   logic              r_fe, r_pe, r_ov;

   assign w_rx_full = (r_rx_cnt == CW'(FIFO_DEPTH));
   assign w_rx_pop  = o_rx_valid && i_rx_ready;
   // A same-cycle pop frees the head slot, so a full FIFO can still take the byte.
   assign w_rx_push = w_rx_wr && (!w_rx_full || w_rx_pop);
   assign w_set_ov  = w_rx_wr && w_rx_full && !w_rx_pop;

   always_ff @(posedge i_clk) begin
      if (w_rx_push) r_rx_mem[r_rx_wr_ptr] <= r_rx_shift;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rx_wr_ptr <= '0;
         r_rx_rd_ptr <= '0;
         r_rx_cnt    <= '0;
         r_fe        <= 1'b0;
         r_pe        <= 1'b0;
         r_ov        <= 1'b0;
      end else begin
         if (w_rx_push) r_rx_wr_ptr <= r_rx_wr_ptr + AW'(1);
         if (w_rx_pop)  r_rx_rd_ptr <= r_rx_rd_ptr + AW'(1);
         case ({w_rx_push, w_rx_pop})
            2'b10:   r_rx_cnt <= r_rx_cnt + CW'(1);
            2'b01:   r_rx_cnt <= r_rx_cnt - CW'(1);
            default: r_rx_cnt <= r_rx_cnt;
         endcase
         // Set beats clear when both land in the same cycle.
         r_fe <= w_set_fe || (r_fe && !i_clr_err);
         r_pe <= w_set_pe || (r_pe && !i_clr_err);
         r_ov <= w_set_ov || (r_ov && !i_clr_err);
      end
   end

   assign o_rx_data       = r_rx_mem[r_rx_rd_ptr];
   assign o_rx_valid      = (r_rx_cnt != '0);
   assign o_rx_count      = r_rx_cnt;
   assign o_rx_frame_err  = r_fe;
   assign o_rx_parity_err = r_pe;
   assign o_rx_overrun    = r_ov;

endmodule
